rdout_dpram_drain: RTL and testbench

- Consumer end of the readout DPRAM that wvb_reader fills.
- On dpram_run, reads dpram_len 32-bit words from the DPRAM and serializes them MSB-first into a framed byte stream: sync, length, payload, optional checksum.
- The byte stream has a valid/ready handshake and feeds the UART TX or another byte sink.
- Pulses dpram_done when the frame is finished, which frees wvb_reader to refill the DPRAM.

---
 rtl/rdout_dpram_drain_pkg.sv | 36 +++
 rtl/rdout_dpram_drain_byte_tx_shifter.sv | 39 +++
 rtl/rdout_dpram_drain.sv | 182 ++++++++++++++++++
 tb/tb_rdout_dpram_drain.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdout_dpram_drain_pkg.sv
// rtl/rdout_dpram_drain_pkg.sv - shared states, constants and helpers for the readout DPRAM drain
// CKSUM_EN follows the DPRAM_DRAIN_CKSUM_EN build macro.
package rdout_dpram_drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD,
    ST_WAIT,
    ST_SEND,
    ST_TRAILER,
    ST_DONE,
    ST_REARM
  } drain_state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int HDR_BYTES  = 3;
  localparam int WORD_BYTES = 4;
  localparam int CKSUM_W    = 16;

`ifdef DPRAM_DRAIN_CKSUM_EN
  localparam bit CKSUM_EN = 1'b1;
`else
  localparam bit CKSUM_EN = 1'b0;
`endif

  localparam int TRAILER_BYTES = CKSUM_EN ? CKSUM_W / 8 : 0;

  // Frame length is limited to the DPRAM depth so the read address never wraps.
  function automatic logic [15:0] clamp_len(input logic [15:0] len, input int adr_w);
    logic [16:0] depth;
    depth = 17'd1 << adr_w;
    return ({1'b0, len} > depth) ? depth[15:0] : len;
  endfunction

endpackage

// File: rtl/rdout_dpram_drain_byte_tx_shifter.sv
// rtl/rdout_dpram_drain_byte_tx_shifter.sv - emits up to 4 bytes of a left-justified word MSB-first over valid/ready
module rdout_dpram_drain_byte_tx_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_cnt,
  input  logic        clear,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        last_acc
);

  logic [31:0] shreg;
  logic [2:0]  cnt;

  assign tx_valid = (cnt != 3'd0);
  assign tx_data  = shreg[31:24];
  assign last_acc = tx_valid && tx_ready && (cnt == 3'd1);

  // Clear wins over load so an abort always drops valid on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= load_data;
      cnt   <= load_cnt;
    end else if (tx_valid && tx_ready) begin
      shreg <= {shreg[23:0], 8'h00};
      cnt   <= cnt - 3'd1;
    end
  end

endmodule

// File: rtl/rdout_dpram_drain.sv
// rtl/rdout_dpram_drain.sv - drains a readout DPRAM frame into a framed byte stream (sync, length, payload)
// Define DPRAM_DRAIN_CKSUM_EN to append a 16-bit additive checksum trailer.
module rdout_dpram_drain
  import rdout_dpram_drain_pkg::*;
#(
  parameter int         P_ADR_WIDTH = 10,
  parameter logic [7:0] P_SYNC      = SYNC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            dpram_len,
  input  logic                   dpram_run,
  output logic                   dpram_busy,
  output logic                   dpram_done,
  output logic                   dpram_rden,
  output logic [P_ADR_WIDTH-1:0] dpram_rd_addr,
  input  logic [31:0]            dpram_rd_data,
  input  logic                   abort,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready
);

  drain_state_e state;
  drain_state_e end_state;
  logic [15:0]  n_len;
  logic [15:0]  wcnt;
  logic [15:0]  wcnt_inc;
  logic [15:0]  len_clamped;
  logic         abort_hit;

  logic         sh_load;
  logic         sh_clear;
  logic         sh_last;
  logic [31:0]  sh_data;
  logic [2:0]   sh_cnt;

  assign len_clamped = clamp_len(dpram_len, P_ADR_WIDTH);
  assign wcnt_inc    = wcnt + 16'd1;
  assign end_state   = (TRAILER_BYTES != 0) ? ST_TRAILER : ST_DONE;
  assign abort_hit   = abort && (state inside {ST_HDR, ST_RD, ST_WAIT, ST_SEND, ST_TRAILER});
  assign sh_clear    = abort_hit;

`ifdef DPRAM_DRAIN_CKSUM_EN
  logic [CKSUM_W-1:0] cksum;
  logic [CKSUM_W-1:0] cksum_add;
  assign cksum_add = cksum + CKSUM_W'(tx_data);
`endif

  // The header and trailer reuse the word shifter as left-justified partial words.
  always_comb begin
    sh_load = 1'b0;
    sh_data = '0;
    sh_cnt  = '0;
    case (state)
      ST_IDLE: begin
        if (dpram_run) begin
          sh_load = 1'b1;
          sh_data = {P_SYNC, len_clamped, 8'h00};
          sh_cnt  = 3'(HDR_BYTES);
        end
      end
      ST_WAIT: begin
        sh_load = 1'b1;
        sh_data = dpram_rd_data;
        sh_cnt  = 3'(WORD_BYTES);
      end
`ifdef DPRAM_DRAIN_CKSUM_EN
      ST_HDR: begin
        if (sh_last && n_len == 16'd0) begin
          sh_load = 1'b1;
          sh_data = {cksum, 16'h0000};
          sh_cnt  = 3'(TRAILER_BYTES);
        end
      end
      ST_SEND: begin
        if (sh_last && wcnt_inc == n_len) begin
          sh_load = 1'b1;
          sh_data = {cksum_add, 16'h0000};
          sh_cnt  = 3'(TRAILER_BYTES);
        end
      end
`endif
      default: ;
    endcase
  end

  rdout_dpram_drain_byte_tx_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .load_data (sh_data),
    .load_cnt  (sh_cnt),
    .clear     (sh_clear),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .last_acc  (sh_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      n_len         <= '0;
      wcnt          <= '0;
      dpram_rd_addr <= '0;
      dpram_rden    <= 1'b0;
      dpram_done    <= 1'b0;
      dpram_busy    <= 1'b0;
`ifdef DPRAM_DRAIN_CKSUM_EN
      cksum         <= '0;
`endif
    end else begin
      dpram_rden <= 1'b0;
      dpram_done <= 1'b0;
      if (abort_hit) begin
        state      <= ST_DONE;
        dpram_done <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (dpram_run) begin
              n_len         <= len_clamped;
              wcnt          <= '0;
              dpram_rd_addr <= '0;
              dpram_busy    <= 1'b1;
              state         <= ST_HDR;
`ifdef DPRAM_DRAIN_CKSUM_EN
              // Length bytes are known at start, so they seed the checksum directly.
              cksum <= CKSUM_W'(len_clamped[15:8]) + CKSUM_W'(len_clamped[7:0]);
`endif
            end
          end
          ST_HDR: begin
            if (sh_last) begin
              if (n_len == 16'd0) begin
                state      <= end_state;
                dpram_done <= (end_state == ST_DONE);
              end else begin
                state      <= ST_RD;
                dpram_rden <= 1'b1;
              end
            end
          end
          ST_RD:   state <= ST_WAIT;
          ST_WAIT: state <= ST_SEND;
          ST_SEND: begin
`ifdef DPRAM_DRAIN_CKSUM_EN
            if (tx_valid && tx_ready) cksum <= cksum_add;
`endif
            if (sh_last) begin
              wcnt <= wcnt_inc;
              if (wcnt_inc == n_len) begin
                state      <= end_state;
                dpram_done <= (end_state == ST_DONE);
              end else begin
                dpram_rd_addr <= dpram_rd_addr + P_ADR_WIDTH'(1);
                dpram_rden    <= 1'b1;
                state         <= ST_RD;
              end
            end
          end
          ST_TRAILER: begin
            if (sh_last) begin
              state      <= ST_DONE;
              dpram_done <= 1'b1;
            end
          end
          ST_DONE: state <= ST_REARM;
          ST_REARM: begin
            if (!dpram_run) begin
              dpram_busy <= 1'b0;
              state      <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rdout_dpram_drain.sv
// tb/tb_rdout_dpram_drain.sv - directed self-checking bench for rdout_dpram_drain
module tb_rdout_dpram_drain;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
`ifdef DPRAM_DRAIN_CKSUM_EN
  localparam int CK = 2;
`else
  localparam int CK = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   dpram_len;
  logic          dpram_run;
  logic          dpram_busy;
  logic          dpram_done;
  logic          dpram_rden;
  logic [AW-1:0] dpram_rd_addr;
  logic [31:0]   dpram_rd_data;
  logic          abort;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;

  logic [31:0] mem [DEPTH];
  int          ready_mode;
  int          checks = 0;
  int          failures = 0;

  logic [7:0]  bq [$];
  int          aq [$];
  int          done_cnt = 0;
  int          rden_err = 0;
  int          stall_err = 0;
  bit          prev_stall = 1'b0;
  bit          prev_abort = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  rdout_dpram_drain #(.P_ADR_WIDTH(AW), .P_SYNC(8'hA5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dpram_len     (dpram_len),
    .dpram_run     (dpram_run),
    .dpram_busy    (dpram_busy),
    .dpram_done    (dpram_done),
    .dpram_rden    (dpram_rden),
    .dpram_rd_addr (dpram_rd_addr),
    .dpram_rd_data (dpram_rd_data),
    .abort         (abort),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready)
  );

  always @(posedge clk) if (dpram_rden) dpram_rd_data <= mem[dpram_rd_addr];

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) bq.push_back(tx_data);
      if (dpram_done) done_cnt++;
      if (dpram_rden) begin
        aq.push_back(int'(dpram_rd_addr));
        if (tx_valid) rden_err++;
      end
      if (prev_stall && !prev_abort && (!tx_valid || tx_data != prev_data)) stall_err++;
    end
    prev_stall = rst_n && tx_valid && !tx_ready;
    prev_data  = tx_data;
    prev_abort = abort;
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ($urandom_range(0, 9) < 3);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_exp(input int n);
    logic [15:0] nn;
    logic [15:0] sum;
    logic [31:0] w32;
    nn = 16'(n);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(nn[15:8]);
    exp_q.push_back(nn[7:0]);
    for (int w = 0; w < n; w++) begin
      w32 = mem[w];
      for (int b = 0; b < 4; b++) exp_q.push_back(w32[31-8*b -: 8]);
    end
    if (CK != 0) begin
      sum = 16'h0000;
      for (int i = 1; i < exp_q.size(); i++) sum = sum + 16'(exp_q[i]);
      exp_q.push_back(sum[15:8]);
      exp_q.push_back(sum[7:0]);
    end
  endtask

  task automatic run_frame(input string tag, input int len, input int mode,
                           input bit timed, input bit rel_reset, output int qb);
    int n, k, ab, db, mism;
    bit seen;
    n = (len > DEPTH) ? DEPTH : len;
    @(posedge clk);
    #1;
    build_exp(n);
    qb = bq.size();
    ab = aq.size();
    db = done_cnt;
    if (rel_reset) rst_n = 1'b1;
    ready_mode = mode;
    dpram_len  = 16'(len);
    dpram_run  = 1'b1;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 30000) begin
      @(negedge clk);
      k++;
      if (timed && k == 1) check({tag, " idle_valid"}, tx_valid, 0);
      if (timed && k == 2) check({tag, " first_byte"}, {tx_valid, tx_data}, {1'b1, 8'hA5});
      if (dpram_done) seen = 1'b1;
    end
    check({tag, " done_seen"}, seen, 1);
    if (timed) check({tag, " cycles"}, k, 5 + 6 * n + CK);
    repeat (4) @(negedge clk);
    #1;
    check({tag, " busy_held"}, dpram_busy, 1);
    check({tag, " no_restart"}, tx_valid, 0);
    check({tag, " done_pulses"}, done_cnt - db, 1);
    check({tag, " byte_count"}, bq.size() - qb, exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (qb + i >= bq.size() || bq[qb+i] !== exp_q[i]) mism++;
    check({tag, " byte_values"}, mism, 0);
    check({tag, " read_count"}, aq.size() - ab, n);
    mism = 0;
    for (int i = 0; i < n; i++)
      if (ab + i >= aq.size() || aq[ab+i] != i) mism++;
    check({tag, " read_addrs"}, mism, 0);
    @(posedge clk);
    #1;
    dpram_run = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, " busy_released"}, dpram_busy, 0);
  endtask

  initial begin
    int qb, k, acc, ab, db, mism;
    logic [7:0] lit [11];
    rst_n      = 1'b0;
    dpram_run  = 1'b0;
    dpram_len  = 16'd0;
    abort      = 1'b0;
    ready_mode = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {tx_valid, tx_data, dpram_busy, dpram_done, dpram_rden, dpram_rd_addr}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_quiet", {tx_valid, dpram_busy, dpram_rden}, 0);

    mem[0] = 32'h01020304;
    mem[1] = 32'hDEADBEEF;
    run_frame("len2", 2, 0, 1'b1, 1'b0, qb);
    lit = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    mism = 0;
    for (int i = 0; i < 11; i++)
      if (qb + i >= bq.size() || bq[qb+i] !== lit[i]) mism++;
    check("len2_literal", mism, 0);

    run_frame("len0", 0, 0, 1'b1, 1'b0, qb);
    check("len0_literal", (bq.size() >= qb + 3) ? {bq[qb], bq[qb+1], bq[qb+2]} : 24'hFFFFFF, 24'hA50000);

    for (int i = 0; i < DEPTH; i++) mem[i] = (i * 32'h00010003) ^ 32'h5A5A0000;
    run_frame("clamp", 16'h0500, 0, 1'b1, 1'b0, qb);
    check("clamp_len_bytes", (bq.size() >= qb + 3) ? {bq[qb+1], bq[qb+2]} : 16'hFFFF, 16'h0400);

    for (int i = 0; i < 16; i++) mem[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    run_frame("stall", 8, 1, 1'b0, 1'b0, qb);
    check("stall_stable", stall_err, 0);
    check("stall_no_rden", rden_err, 0);

    @(posedge clk);
    #1;
    build_exp(10);
    qb = bq.size();
    ab = aq.size();
    db = done_cnt;
    ready_mode = 0;
    dpram_len  = 16'd10;
    dpram_run  = 1'b1;
    acc = 0;
    k = 0;
    while (acc < 12 && k < 1000) begin
      @(negedge clk);
      k++;
      if (tx_valid && tx_ready) acc++;
    end
    check("abort_reached", acc, 12);
    @(posedge clk);
    #1;
    abort = 1'b1;
    ready_mode = 2;
    @(negedge clk);
    check("abort_held_byte", {tx_valid, tx_data}, {1'b1, exp_q[12]});
    @(posedge clk);
    #1;
    abort = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    check("abort_valid_drop", tx_valid, 0);
    check("abort_done", dpram_done, 1);
    repeat (6) @(negedge clk);
    #1;
    check("abort_done_pulses", done_cnt - db, 1);
    check("abort_reads", aq.size() - ab, 3);
    check("abort_byte_count", bq.size() - qb, 12);
    mism = 0;
    for (int i = 0; i < 12; i++)
      if (qb + i >= bq.size() || bq[qb+i] !== exp_q[i]) mism++;
    check("abort_byte_values", mism, 0);
    check("abort_busy_held", dpram_busy, 1);
    @(posedge clk);
    #1;
    dpram_run = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_released", dpram_busy, 0);
    run_frame("restart", 2, 0, 1'b1, 1'b0, qb);

    @(posedge clk);
    #1;
    ready_mode = 0;
    dpram_len  = 16'd4;
    dpram_run  = 1'b1;
    acc = 0;
    k = 0;
    while (acc < 6 && k < 1000) begin
      @(negedge clk);
      k++;
      if (tx_valid && tx_ready) acc++;
    end
    check("rst_reached_send", acc, 6);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_outputs", {tx_valid, tx_data, dpram_busy, dpram_done, dpram_rden, dpram_rd_addr}, 0);
    end
    run_frame("post_reset", 4, 0, 1'b1, 1'b1, qb);

    check("final_stall_stable", stall_err, 0);
    check("final_no_rden_with_valid", rden_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
